// File: rtl/frv_rng_pool_pkg.sv
// Shared definitions for the FRV RNG interface unit: request opcodes and status codes.
package frv_rng_pool_pkg;

    // One-hot request opcodes presented by the execute stage.
    localparam logic [2:0] RNG_IF_SEED = 3'b001;
    localparam logic [2:0] RNG_IF_SAMP = 3'b010;
    localparam logic [2:0] RNG_IF_TEST = 3'b100;

    // Three-state RNG interface status, also used as the FSM state encoding.
    typedef enum logic [2:0] {
        RNG_IF_STAT_NO_INIT = 3'b000,
        RNG_IF_INIT_NO_ENTR = 3'b100,
        RNG_IF_INIT_HEALTHY = 3'b101
    } rng_status_t;

endpackage

// File: rtl/frv_rng_pool_if.sv
// Request/response channel between the execute stage (master) and the RNG pool (slave).
interface frv_rng_pool_if
    import frv_rng_pool_pkg::*;
#(
    parameter int XLEN = 32
) ();

    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [XLEN-1:0]   req_data;
    logic              rsp_valid;
    logic              rsp_ready;
    rng_status_t       rsp_status;
    logic [XLEN-1:0]   rsp_data;

    modport master (
        output req_valid, req_op, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_status, rsp_data
    );

    modport slave (
        input  req_valid, req_op, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_status, rsp_data
    );

endinterface

// File: rtl/frv_rng_fifo.sv
// Small power-of-two FIFO holding conditioned random words; head entry is read combinationally.
module frv_rng_fifo #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                       g_clk,
    input  logic                       g_resetn,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [XLEN-1:0]            wdata,
    output logic [XLEN-1:0]            rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [XLEN-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage array; a full FIFO may still accept a word when the head leaves in the same cycle.
    always_ff @(posedge g_clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy tracking; flush wins over any push or pop.
    always_ff @(posedge g_clk) begin
        if (!g_resetn || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/frv_rng_pool.sv
// RNG interface unit: conditions raw entropy through a Galois LFSR, pools completed
// words and answers SEED / SAMP / TEST requests with a one-cycle registered response.
module frv_rng_pool
    import frv_rng_pool_pkg::*;
#(
    parameter int              XLEN   = 32,
    parameter int              DEPTH  = 4,
    parameter int              THRESH = 2,
    parameter logic [XLEN-1:0] TAPS   = 32'h80200003
) (
    input  logic               g_clk,
    input  logic               g_resetn,
    frv_rng_pool_if.slave      bus,
    input  logic               ent_valid,
    input  logic               ent_bit
);

    localparam int BW = $clog2(XLEN);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] THRESH_C = CW'(THRESH);

    rng_status_t     state;
    rng_status_t     status_next;
    logic [XLEN-1:0] lfsr;
    logic [XLEN-1:0] lfsr_step;
    logic [XLEN-1:0] seed_mix;
    logic [XLEN-1:0] seed_val;
    logic [XLEN-1:0] pool_head;
    logic [BW-1:0]   bitcnt;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic            full;
    logic            empty;
    logic            accept;
    logic            is_seed;
    logic            is_samp;
    logic            word_done;
    logic            step;
    logic            push;
    logic            pop;

    assign bus.req_ready = !bus.rsp_valid || bus.rsp_ready;

    // Decode the accepted request, the fill step, pool traffic and the resulting status.
    always_comb begin
        accept      = bus.req_valid && bus.req_ready;
        is_seed     = accept && (bus.req_op == RNG_IF_SEED);
        is_samp     = accept && (bus.req_op == RNG_IF_SAMP);
        pop         = is_samp && (state == RNG_IF_INIT_HEALTHY) && !empty;
        word_done   = (bitcnt == BW'(XLEN - 1));
        step        = (state != RNG_IF_STAT_NO_INIT) && ent_valid && !is_seed
                      && !(word_done && full && !pop);
        push        = step && word_done;
        lfsr_step   = {lfsr[XLEN-2:0], 1'b0} ^ (lfsr[XLEN-1] ? TAPS : '0)
                      ^ {{(XLEN-1){1'b0}}, ent_bit};
        seed_mix    = lfsr ^ bus.req_data;
        seed_val    = (seed_mix == '0) ? {{(XLEN-1){1'b0}}, 1'b1} : seed_mix;
        count_next  = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
        status_next = state;
        if (is_seed) begin
            status_next = RNG_IF_INIT_NO_ENTR;
        end else if (state != RNG_IF_STAT_NO_INIT) begin
            status_next = (count_next >= THRESH_C) ? RNG_IF_INIT_HEALTHY : RNG_IF_INIT_NO_ENTR;
        end
    end

    frv_rng_fifo #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) u_fifo (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .push     (push),
        .pop      (pop),
        .flush    (is_seed),
        .wdata    (lfsr_step),
        .rdata    (pool_head),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    // Status FSM together with the LFSR and bit counter it gates.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state  <= RNG_IF_STAT_NO_INIT;
            lfsr   <= '0;
            bitcnt <= '0;
        end else begin
            state <= status_next;
            if (is_seed) begin
                lfsr   <= seed_val;
                bitcnt <= '0;
            end else if (step) begin
                lfsr   <= lfsr_step;
                bitcnt <= bitcnt + BW'(1);
            end
        end
    end

    // Response register: loaded on accept, held until the execute stage consumes it.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            bus.rsp_valid  <= 1'b0;
            bus.rsp_status <= RNG_IF_STAT_NO_INIT;
            bus.rsp_data   <= '0;
        end else if (accept) begin
            bus.rsp_valid <= 1'b1;
            if (is_seed) begin
                bus.rsp_status <= RNG_IF_INIT_NO_ENTR;
                bus.rsp_data   <= '0;
            end else if (pop) begin
                bus.rsp_status <= status_next;
                bus.rsp_data   <= pool_head;
            end else begin
                bus.rsp_status <= state;
                bus.rsp_data   <= '0;
            end
        end else if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_frv_rng_pool.sv
// Scoreboard bench for frv_rng_pool: a behavioural pool model predicts each response,
// a separate monitor compares whenever a response is consumed.
module tb_frv_rng_pool;
    import frv_rng_pool_pkg::*;

    localparam int          XLEN   = 32;
    localparam int          DEPTH  = 4;
    localparam int          THRESH = 2;
    localparam logic [31:0] TAPS   = 32'h80200003;

    typedef struct {
        logic [2:0]  status;
        logic [31:0] data;
        string       name;
    } exp_t;

    logic g_clk     = 1'b0;
    logic g_resetn  = 1'b0;
    logic ent_valid = 1'b0;
    logic ent_bit   = 1'b0;

    int checks   = 0;
    int failures = 0;

    exp_t        sb[$];
    logic [31:0] m_lfsr;
    logic [31:0] m_pool[$];
    int          m_bitcnt;
    bit          m_init;
    bit          m_pending;

    frv_rng_pool_if #(.XLEN(XLEN)) bus ();

    frv_rng_pool #(
        .XLEN   (XLEN),
        .DEPTH  (DEPTH),
        .THRESH (THRESH),
        .TAPS   (TAPS)
    ) dut (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .bus       (bus),
        .ent_valid (ent_valid),
        .ent_bit   (ent_bit)
    );

    always #5 g_clk = ~g_clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] modelStatus();
        if (!m_init) return 3'b000;
        return (m_pool.size() >= THRESH) ? 3'b101 : 3'b100;
    endfunction

    task automatic doReset(input int n);
        @(negedge g_clk);
        g_resetn      = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = RNG_IF_TEST;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b1;
        ent_valid     = 1'b0;
        ent_bit       = 1'b0;
        sb.delete();
        m_pool.delete();
        m_lfsr    = '0;
        m_bitcnt  = 0;
        m_init    = 1'b0;
        m_pending = 1'b0;
        repeat (n - 1) @(negedge g_clk);
        #1;
        checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rst_rsp_status", 32'(bus.rsp_status), 32'd0);
        checkOutput("rst_rsp_data", bus.rsp_data, 32'd0);
        checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd1);
    endtask

    // One clock of stimulus; the model advances by the rules of the pool and queues expectations.
    task automatic applyStimulus(input bit v, input logic [2:0] op, input logic [31:0] d,
                                 input bit rr, input bit ev, input bit eb, input string name);
        bit          rdy_m;
        bit          acc;
        bit          pop;
        logic [2:0]  cur;
        logic [31:0] word;
        exp_t        e;
        @(negedge g_clk);
        g_resetn      = 1'b1;
        bus.req_valid = v;
        bus.req_op    = op;
        bus.req_data  = d;
        bus.rsp_ready = rr;
        ent_valid     = ev;
        ent_bit       = eb;
        #1;
        rdy_m = !m_pending || rr;
        checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'(m_pending));
        checkOutput("req_ready", 32'(bus.req_ready), 32'(rdy_m));
        acc    = v && rdy_m;
        cur    = modelStatus();
        e.name = name;
        if (acc && op == RNG_IF_SEED) begin
            m_lfsr = m_lfsr ^ d;
            if (m_lfsr == 0) m_lfsr = 32'd1;
            m_bitcnt = 0;
            m_pool.delete();
            m_init   = 1'b1;
            e.status = 3'b100;
            e.data   = 32'd0;
            sb.push_back(e);
        end else begin
            pop  = acc && (op == RNG_IF_SAMP) && (cur == 3'b101);
            word = 32'd0;
            if (pop) word = m_pool.pop_front();
            if (m_init && ev && !(m_bitcnt == XLEN - 1 && m_pool.size() == DEPTH)) begin
                m_lfsr = (m_lfsr << 1) ^ (m_lfsr[31] ? TAPS : 32'd0) ^ 32'(eb);
                m_bitcnt++;
                if (m_bitcnt == XLEN) begin
                    m_bitcnt = 0;
                    m_pool.push_back(m_lfsr);
                end
            end
            if (acc) begin
                e.status = pop ? modelStatus() : cur;
                e.data   = word;
                sb.push_back(e);
            end
        end
        m_pending = acc ? 1'b1 : (m_pending && !rr);
    endtask

    task automatic idle(input int n, input bit ev, input bit eb);
        for (int i = 0; i < n; i++) applyStimulus(0, RNG_IF_TEST, 32'd0, 1, ev, eb, "idle");
    endtask

    task automatic entRandom(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, RNG_IF_TEST, 32'd0, 1, 1, 1'($urandom_range(0, 1)), "ent");
    endtask

    // Monitor: compares consumed responses against the scoreboard and checks hold stability.
    initial begin
        bit          hold = 1'b0;
        logic [2:0]  h_status;
        logic [31:0] h_data;
        exp_t        e;
        forever begin
            @(negedge g_clk);
            #4;
            if (!g_resetn) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    checkOutput("hold_valid", 32'(bus.rsp_valid), 32'd1);
                    checkOutput("hold_status", 32'(bus.rsp_status), 32'(h_status));
                    checkOutput("hold_data", bus.rsp_data, h_data);
                end
                if (bus.rsp_valid && bus.rsp_ready) begin
                    hold = 1'b0;
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_rsp", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        checkOutput({e.name, "_status"}, 32'(bus.rsp_status), 32'(e.status));
                        checkOutput({e.name, "_data"}, bus.rsp_data, e.data);
                    end
                end else if (bus.rsp_valid) begin
                    hold     = 1'b1;
                    h_status = bus.rsp_status;
                    h_data   = bus.rsp_data;
                end else begin
                    hold = 1'b0;
                end
            end
        end
    end

    // Directed scenarios followed by a randomized run.
    initial begin
        logic [2:0] op;
        int         r;
        bus.req_valid = 1'b0;
        bus.req_op    = RNG_IF_TEST;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b1;

        doReset(3);
        applyStimulus(1, RNG_IF_TEST, 32'h0, 1, 0, 0, "test_noinit");
        applyStimulus(1, RNG_IF_SAMP, 32'h0, 1, 0, 0, "samp_noinit");

        applyStimulus(1, RNG_IF_SEED, 32'h0, 1, 0, 0, "seed_zero");
        idle(32, 1, 0);
        applyStimulus(1, RNG_IF_TEST, 32'h0, 1, 0, 0, "test_one_word");
        idle(32, 1, 0);
        applyStimulus(1, RNG_IF_TEST, 32'h0, 1, 0, 0, "test_healthy");

        doReset(2);
        applyStimulus(1, RNG_IF_SEED, 32'h1, 1, 0, 0, "seed_one");
        idle(32, 1, 0);
        applyStimulus(1, RNG_IF_SAMP, 32'h0, 1, 0, 0, "samp_below_thresh");
        idle(1, 0, 0);
        applyStimulus(1, RNG_IF_SAMP, 32'h0, 1, 0, 0, "samp_empty");

        entRandom(4 * XLEN + XLEN - 1 + 10);
        applyStimulus(1, RNG_IF_SAMP, 32'h0, 1, 1, 1, "samp_full_push");
        applyStimulus(1, RNG_IF_TEST, 32'h0, 1, 0, 0, "test_still_full");
        for (int i = 0; i < 5; i++) applyStimulus(1, RNG_IF_SAMP, 32'h0, 1, 0, 0, "samp_drain");

        applyStimulus(1, RNG_IF_SEED, $urandom, 1, 0, 0, "seed_pre_fill");
        entRandom(3 * XLEN + 17);
        applyStimulus(1, RNG_IF_SEED, 32'h0, 1, 1, 1, "seed_mid_fill");
        applyStimulus(1, RNG_IF_SAMP, 32'h0, 1, 0, 0, "samp_after_seed");
        entRandom(2 * XLEN);
        applyStimulus(1, RNG_IF_SAMP, 32'h0, 1, 0, 0, "samp_refilled");

        applyStimulus(1, RNG_IF_TEST, 32'h0, 0, 0, 0, "test_stalled");
        for (int i = 0; i < 5; i++) applyStimulus(1, RNG_IF_SAMP, 32'h0, 0, 1, 0, "stall");
        doReset(2);

        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 5)       op = RNG_IF_SEED;
            else if (r < 50) op = RNG_IF_SAMP;
            else if (r < 80) op = RNG_IF_TEST;
            else             op = 3'($urandom_range(0, 7));
            applyStimulus($urandom_range(0, 99) < 60, op, $urandom,
                          $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 85,
                          1'($urandom_range(0, 1)), "rand");
        end

        idle(4, 0, 0);
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
